// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU MEM-stage request, external requester,
// and the DataMem port.
//   slave  : the arbiter side (consumes requests + mem_rdata, drives the rest)
//   master : the environment side (pipeline, external agent, DataMem)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU (MEM stage)
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [2:0]        cpu_funct3;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // external requester
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;
  // DataMem port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    input  ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, ext_gnt, ext_rvalid, ext_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, mem_funct3
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    output ext_req, ext_we, ext_addr, ext_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, ext_gnt, ext_rvalid, ext_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, mem_funct3
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and an external
// requester. CPU has default priority; a starvation counter forces the port
// to EXT after STARVE_MAX contended cycles, and a burst counter hands it back
// after EXT_MAX_BURST grants when the CPU is waiting.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dmem_arbiter_if.slave (CPU request, ext request, DataMem port)
module dmem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int STARVE_MAX    = 4,
  parameter int EXT_MAX_BURST = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(EXT_MAX_BURST + 1);
  localparam logic [SW-1:0] S_SAT = SW'(STARVE_MAX);
  localparam logic [BW-1:0] B_SAT = BW'(EXT_MAX_BURST);
  localparam logic [2:0]    F3_WORD = 3'b010;

  typedef enum logic {OWN_CPU, OWN_EXT} own_e;

  own_e              own_q, own_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic [ADDR_W-1:0] addr_mux;
  logic              eff_ext;

  // EXT only really owns the port while it is still asking; a dropped
  // ext_req hands the cycle straight back to the CPU.
  assign eff_ext = (own_q == OWN_EXT) && bus.ext_req;

  always_comb begin
    addr_mux       = bus.cpu_addr;
    bus.mem_wdata  = bus.cpu_wdata;
    bus.mem_we     = bus.cpu_req & bus.cpu_we;
    bus.mem_re     = bus.cpu_req & ~bus.cpu_we;
    bus.mem_funct3 = bus.cpu_funct3;
    bus.ext_gnt    = 1'b0;
    bus.cpu_stall  = 1'b0;
    if (eff_ext) begin
      addr_mux       = bus.ext_addr;
      bus.mem_wdata  = bus.ext_wdata;
      bus.mem_we     = bus.ext_we;
      bus.mem_re     = ~bus.ext_we;
      bus.mem_funct3 = F3_WORD;
      bus.ext_gnt    = 1'b1;
      bus.cpu_stall  = bus.cpu_req;
    end
  end

  assign bus.mem_addr   = addr_mux;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_rdata  = ext_rdata_q;

  always_comb begin
    own_d        = own_q;
    starve_cnt_d = starve_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (own_q)
      OWN_CPU: begin
        if (!bus.ext_req) begin
          starve_cnt_d = '0;
        end else if (!bus.cpu_req || (int'(starve_cnt_q) + 1 >= STARVE_MAX)) begin
          own_d        = OWN_EXT;
          starve_cnt_d = '0;
          burst_cnt_d  = '0;
        end else if (starve_cnt_q != S_SAT) begin
          starve_cnt_d = starve_cnt_q + SW'(1);
        end
      end
      OWN_EXT: begin
        if (!bus.ext_req || (bus.cpu_req && (int'(burst_cnt_q) + 1 >= EXT_MAX_BURST))) begin
          own_d        = OWN_CPU;
          starve_cnt_d = '0;
          burst_cnt_d  = '0;
        end else if (burst_cnt_q != B_SAT) begin
          // saturates when the CPU is idle, so EXT may keep the port forever
          burst_cnt_d = burst_cnt_q + BW'(1);
        end
      end
      default: own_d = OWN_CPU;
    endcase
  end

  always_comb begin
    ext_rvalid_d = eff_ext & ~bus.ext_we;
    ext_rdata_d  = ext_rvalid_d ? bus.mem_rdata : ext_rdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_q        <= OWN_CPU;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      own_q        <= own_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter. Each stimulus cycle pushes its
// hand-computed expected port values into a queue; a negedge monitor pops
// and compares them against the DUT. A small word memory models DataMem.
module tb_dmem_arbiter;
  localparam logic [31:0] C   = 32'h0000_0100;
  localparam logic [31:0] X40 = 32'h0000_0040;
  localparam logic [31:0] X44 = 32'h0000_0044;
  localparam logic [31:0] D1  = 32'hDEAD_BEEF;
  localparam logic [31:0] D2  = 32'h1234_5678;
  localparam logic [2:0]  FC  = 3'b000;
  localparam logic [2:0]  FW  = 3'b010;

  typedef struct {
    logic        gnt, stall, we, re;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic        rv;
    logic [31:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .EXT_MAX_BURST(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // DataMem: combinational read, write at the clock edge
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ext_gnt",    32'(bus.ext_gnt),    32'(e.gnt));
      chk("cpu_stall",  32'(bus.cpu_stall),  32'(e.stall));
      chk("mem_we",     32'(bus.mem_we),     32'(e.we));
      chk("mem_re",     32'(bus.mem_re),     32'(e.re));
      chk("mem_addr",   bus.mem_addr,        e.addr);
      chk("mem_funct3", 32'(bus.mem_funct3), 32'(e.f3));
      chk("ext_rvalid", 32'(bus.ext_rvalid), 32'(e.rv));
      if (e.rv) chk("ext_rdata", bus.ext_rdata, e.rd);
    end
  end

  task automatic set_in(input logic cr, cw, er, ew, input logic [31:0] ea, ewd);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.ext_req   = er;
    bus.ext_we    = ew;
    bus.ext_addr  = ea;
    bus.ext_wdata = ewd;
  endtask

  task automatic push(input logic g, s, we, re, input logic [31:0] a,
                      input logic [2:0] f, input logic rv, input logic [31:0] rd);
    exp_t e;
    e.gnt = g; e.stall = s; e.we = we; e.re = re;
    e.addr = a; e.f3 = f; e.rv = rv; e.rd = rd;
    q.push_back(e);
  endtask

  // one cycle: drive inputs, queue expectation, advance to posedge+1
  task automatic vec(input logic cr, cw, er, ew, input logic [31:0] ea, ewd,
                     input logic g, s, we, re, input logic [31:0] a,
                     input logic [2:0] f, input logic rv, input logic [31:0] rd);
    set_in(cr, cw, er, ew, ea, ewd);
    push(g, s, we, re, a, f, rv, rd);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    bus.cpu_addr   = C;
    bus.cpu_wdata  = 32'hCAFE_0000;
    bus.cpu_funct3 = FC;
    set_in(0, 0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // reset held with both sides requesting: CPU path, no grant
    vec(1,0,1,0,X40,0,  0,0,0,1,C,FC,0,0);
    vec(1,0,1,0,X40,0,  0,0,0,1,C,FC,0,0);
    reset = 1'b1;

    // CPU idle: ext write, then read back
    vec(0,0,1,1,X40,D1, 0,0,0,0,C,FC,0,0);
    vec(0,0,1,1,X40,D1, 1,0,1,0,X40,FW,0,0);
    vec(0,0,1,0,X40,0,  1,0,0,1,X40,FW,0,0);
    vec(0,0,0,0,X40,0,  0,0,0,0,C,FC,1,D1);

    // contention from idle: 4 CPU cycles, 4 EXT reads, then CPU
    for (int i = 0; i < 4; i++) vec(1,0,1,0,X40,0, 0,0,0,1,C,FC,0,0);
    for (int i = 0; i < 4; i++) vec(1,0,1,0,X40,0, 1,1,0,1,X40,FW,(i > 0),(i > 0) ? D1 : 32'h0);
    vec(1,0,1,1,X44,D2, 0,0,0,1,C,FC,1,D1);
    for (int i = 0; i < 3; i++) vec(1,0,1,1,X44,D2, 0,0,0,1,C,FC,0,0);
    // two EXT writes, then ext_req drops: CPU served same cycle
    for (int i = 0; i < 2; i++) vec(1,0,1,1,X44,D2, 1,1,1,0,X44,FW,0,0);
    vec(1,0,0,0,X44,0,  0,0,0,1,C,FC,0,0);
    // counters were cleared: a full 4 CPU cycles before EXT again
    for (int i = 0; i < 4; i++) vec(1,0,1,1,X44,D2, 0,0,0,1,C,FC,0,0);
    vec(1,0,1,1,X44,D2, 1,1,1,0,X44,FW,0,0);
    // CPU write while ext released
    vec(1,1,0,0,X44,0,  0,0,1,0,C,FC,0,0);

    // CPU idle, ext_req held: no burst limit
    vec(0,0,1,0,X44,0,  0,0,0,0,C,FC,0,0);
    for (int k = 1; k <= 10; k++) vec(0,0,1,0,X44,0, 1,0,0,1,X44,FW,(k >= 2),(k >= 2) ? D2 : 32'h0);
    vec(0,0,0,0,X44,0,  0,0,0,0,C,FC,1,D2);

    // reset asserted during an EXT read grant
    vec(0,0,1,0,X40,0,  0,0,0,0,C,FC,0,0);
    set_in(1, 0, 1, 0, X40, 32'h0);
    push(1,1,0,1,X40,FW,0,0);
    #6 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    vec(1,0,1,0,X40,0,  0,0,0,1,C,FC,0,0);
    vec(0,0,0,0,X40,0,  0,0,0,0,C,FC,0,0);

    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
